// File: rtl/mem_port_arbiter.sv
// Single-ported, fixed-latency memory shared by the IF (fetch) and MEM (load/store) stages.
// One access in flight; per-stage stall levels; squashed fetches are drained without a done pulse.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_stall,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int             SW   = $clog2(STARVE_MAX + 1);
    localparam logic [3:0]     LAT  = 4'(MEM_LAT);
    localparam logic [SW-1:0]  SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [3:0]    lat_cnt;
    logic [SW-1:0] starve_cnt;
    logic          last;
    logic          slot_end;   // cycle after an access ends: keeps grants off the done cycle
    logic          cur_we;
    logic          grant_if, grant_mem;
    logic          if_done_nxt, mem_done_nxt;
    logic          if_done_q, mem_done_q;

    assign last = (lat_cnt == 4'd1);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        grant_if     = 1'b0;
        grant_mem    = 1'b0;
        if_done_nxt  = 1'b0;
        mem_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!slot_end) begin
                    // A fetch being redirected this cycle is not worth starting.
                    if (if_req && !if_flush && (!mem_req || starve_cnt == SMAX))
                        grant_if = 1'b1;
                    else if (mem_req)
                        grant_mem = 1'b1;
                end
                if (grant_if)       state_nxt = BUSY_IF;
                else if (grant_mem) state_nxt = BUSY_MEM;
            end
            BUSY_IF: begin
                if (last) begin
                    state_nxt   = IDLE;
                    if_done_nxt = !if_flush;
                end else if (if_flush) begin
                    state_nxt = DRAIN;
                end
            end
            BUSY_MEM: begin
                if (last) begin
                    state_nxt    = IDLE;
                    mem_done_nxt = 1'b1;
                end
            end
            DRAIN: begin
                if (last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            cur_we     <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            slot_end   <= 1'b0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            m_en       <= grant_if | grant_mem;
            m_we       <= grant_mem & mem_we;
            if_done_q  <= if_done_nxt;
            mem_done_q <= mem_done_nxt;
            slot_end   <= (state != IDLE) && last;
            if (grant_if || grant_mem) begin
                m_addr  <= grant_mem ? mem_addr : if_addr;
                m_wdata <= grant_mem ? mem_wdata : '0;
                cur_we  <= grant_mem & mem_we;
                lat_cnt <= LAT;
            end else if (lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (!if_req || grant_if)
                starve_cnt <= '0;
            else if (grant_mem && starve_cnt != SMAX)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign if_done     = if_done_q;
    assign mem_done    = mem_done_q;
    assign if_rdata    = if_done_q ? mem_rdata : '0;
    assign mem_rdata_o = (mem_done_q && !cur_we) ? mem_rdata : '0;
    assign if_stall    = if_req & ~if_done_q;
    assign mem_stall   = mem_req & ~mem_done_q;

endmodule
